// File: rtl/interval_meter_pkg.sv
// Shared timer definitions for the interval meter.
// FSM state encodings and block-level constants.
package interval_meter_pkg;

   localparam int DEF_N = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/interval_meter_if.sv
// Measurement control and result bundle for the interval meter.
// master drives start/stop/ack/limit; slave returns the result.
interface interval_meter_if #(
   parameter int N = 10
);

   logic         start;
   logic         stop;
   logic [N-1:0] limit_val;
   logic         ack;
   logic [N-1:0] elapsed;
   logic         valid;
   logic         overflow;
   logic         busy;

   modport master (
      output start, stop, limit_val, ack,
      input  elapsed, valid, overflow, busy
   );

   modport slave (
      input  start, stop, limit_val, ack,
      output elapsed, valid, overflow, busy
   );

endinterface

// File: rtl/interval_meter.sv
// Cycle-accurate start/stop interval meter with limit overflow.
// Result is held until the consumer acknowledges it.
module interval_meter
   import interval_meter_pkg::*;
#(
   parameter int N = DEF_N
) (
   input logic             clk,
   input logic             rst,
   interval_meter_if.slave bus
);

   localparam logic [N-1:0] ONE = N'(1);

   state_t       state, state_n;
   logic [N-1:0] count, count_n;
   logic [N-1:0] elapsed_q, elapsed_n;
   logic         valid_q, valid_n;
   logic         ovf_q, ovf_n;
   logic         busy_q, busy_n;
   logic [N-1:0] eff_limit;

   // A zero limit means "measure up to the counter's full range".
   assign eff_limit = (bus.limit_val == '0) ? '1 : bus.limit_val;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         count     <= '0;
         elapsed_q <= '0;
         valid_q   <= 1'b0;
         ovf_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state     <= state_n;
         count     <= count_n;
         elapsed_q <= elapsed_n;
         valid_q   <= valid_n;
         ovf_q     <= ovf_n;
         busy_q    <= busy_n;
      end
   end

   always_comb begin
      state_n   = state;
      count_n   = count;
      elapsed_n = elapsed_q;
      valid_n   = valid_q;
      ovf_n     = ovf_q;
      busy_n    = busy_q;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               state_n = RUN;
               count_n = ONE;
               busy_n  = 1'b1;
               valid_n = 1'b0;
               ovf_n   = 1'b0;
            end
         end
         RUN: begin
            // Restart beats stop, and stop beats the limit.
            if (bus.start) begin
               count_n = ONE;
            end else if (bus.stop) begin
               elapsed_n = count;
               ovf_n     = 1'b0;
               valid_n   = 1'b1;
               busy_n    = 1'b0;
               state_n   = HOLD;
            end else if (count == eff_limit) begin
               elapsed_n = eff_limit;
               ovf_n     = 1'b1;
               valid_n   = 1'b1;
               busy_n    = 1'b0;
               state_n   = HOLD;
            end else begin
               count_n = count + ONE;
            end
         end
         HOLD: begin
            if (bus.ack) begin
               valid_n = 1'b0;
               ovf_n   = 1'b0;
               if (bus.start) begin
                  state_n = RUN;
                  count_n = ONE;
                  busy_n  = 1'b1;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: begin
            state_n = IDLE;
            valid_n = 1'b0;
            ovf_n   = 1'b0;
            busy_n  = 1'b0;
         end
      endcase
   end

   assign bus.elapsed  = elapsed_q;
   assign bus.valid    = valid_q;
   assign bus.overflow = ovf_q;
   assign bus.busy     = busy_q;

endmodule

// File: tb/tb_interval_meter.sv
// Self-checking bench for interval_meter: vector table,
// directed corner sequences and a timestamp-based random model.
module tb_interval_meter;

   localparam int N = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   interval_meter_if #(.N(N)) bus ();

   interval_meter #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic s, p, a;
      int   lim;
      int   el;
      logic v, o, b;
   } vec_t;

   vec_t tbl [19];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   task automatic chk_out(input string nm, input int el,
                          input logic v, input logic o, input logic b);
      checks++;
      if (int'(bus.elapsed) != el || bus.valid !== v ||
          bus.overflow !== o || bus.busy !== b) begin
         failures++;
         $display("FAIL %s actual el=%0d v=%b o=%b b=%b required el=%0d v=%b o=%b b=%b",
                  nm, bus.elapsed, bus.valid, bus.overflow, bus.busy,
                  el, v, o, b);
      end
   endtask

   task automatic drive(input logic s, input logic p,
                        input logic a, input int l);
      bus.start     = s;
      bus.stop      = p;
      bus.ack       = a;
      bus.limit_val = l[N-1:0];
   endtask

   // One rising edge; return on the following falling edge.
   task automatic cyc1();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      drive(0, 0, 0, 0);
      #1;
      chk_out("reset_state", 0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic idle_edges(input int n, input int l);
      for (int i = 0; i < n; i++) begin
         drive(0, 0, 0, l);
         cyc1();
      end
   endtask

   // Timestamp reference: count at an edge is edge index minus start edge.
   int   m_mode;
   int   m_t0;
   int   m_cyc;
   int   m_el;
   logic m_ovf;

   task automatic model_edge(input logic s, input logic p,
                             input logic a, input int l);
      int eff;
      eff = (l == 0) ? (1 << N) - 1 : l;
      case (m_mode)
         0: if (s) begin
            m_mode = 1;
            m_t0   = m_cyc;
         end
         1: begin
            if (s) m_t0 = m_cyc;
            else if (p) begin
               m_el   = m_cyc - m_t0;
               m_ovf  = 1'b0;
               m_mode = 2;
            end else if (m_cyc - m_t0 == eff) begin
               m_el   = eff;
               m_ovf  = 1'b1;
               m_mode = 2;
            end
         end
         default: if (a) begin
            m_ovf  = 1'b0;
            m_mode = s ? 1 : 0;
            if (s) m_t0 = m_cyc;
         end
      endcase
      m_cyc++;
   endtask

   initial begin
      int n;
      int lim;
      logic s, p, a;

      drive(0, 0, 0, 0);

      tbl[0]  = '{1, 0, 0, 3, 0, 0, 0, 1};
      tbl[1]  = '{0, 0, 0, 3, 0, 0, 0, 1};
      tbl[2]  = '{0, 0, 0, 3, 0, 0, 0, 1};
      tbl[3]  = '{0, 0, 0, 3, 3, 1, 1, 0};
      tbl[4]  = '{1, 0, 0, 3, 3, 1, 1, 0};
      tbl[5]  = '{0, 0, 1, 3, 3, 0, 0, 0};
      tbl[6]  = '{0, 1, 0, 3, 3, 0, 0, 0};
      tbl[7]  = '{1, 0, 0, 3, 3, 0, 0, 1};
      tbl[8]  = '{0, 1, 0, 3, 1, 1, 0, 0};
      tbl[9]  = '{1, 0, 1, 3, 1, 0, 0, 1};
      tbl[10] = '{1, 1, 0, 3, 1, 0, 0, 1};
      tbl[11] = '{0, 0, 0, 3, 1, 0, 0, 1};
      tbl[12] = '{0, 1, 0, 3, 2, 1, 0, 0};
      tbl[13] = '{0, 0, 1, 3, 2, 0, 0, 0};
      tbl[14] = '{1, 0, 0, 3, 2, 0, 0, 1};
      tbl[15] = '{0, 0, 0, 3, 2, 0, 0, 1};
      tbl[16] = '{0, 0, 0, 3, 2, 0, 0, 1};
      tbl[17] = '{0, 1, 0, 3, 3, 1, 0, 0};
      tbl[18] = '{0, 0, 1, 3, 3, 0, 0, 0};

      do_reset();
      for (int i = 0; i < 19; i++) begin
         drive(tbl[i].s, tbl[i].p, tbl[i].a, tbl[i].lim);
         cyc1();
         chk_out($sformatf("vec%0d", i), tbl[i].el,
                 tbl[i].v, tbl[i].o, tbl[i].b);
      end

      // stop 25 edges after start
      do_reset();
      drive(1, 0, 0, 100);
      cyc1();
      idle_edges(24, 100);
      drive(0, 1, 0, 100);
      cyc1();
      chk_out("stop25", 25, 1, 0, 0);
      idle_edges(3, 100);
      chk_out("stop25_hold", 25, 1, 0, 0);
      drive(0, 0, 1, 100);
      cyc1();
      chk_out("stop25_ack", 25, 0, 0, 0);

      // limit 8 overflow, then stop coinciding with the limit
      drive(1, 0, 0, 8);
      cyc1();
      n = 0;
      do begin
         drive(0, 0, 0, 8);
         cyc1();
         n++;
      end while (!bus.valid && n < 40);
      chk("lim8_edges", n, 8);
      chk_out("lim8_ovf", 8, 1, 1, 0);
      drive(0, 0, 1, 8);
      cyc1();
      drive(1, 0, 0, 8);
      cyc1();
      idle_edges(7, 8);
      drive(0, 1, 0, 8);
      cyc1();
      chk_out("lim8_stop_wins", 8, 1, 0, 0);
      drive(0, 0, 1, 8);
      cyc1();

      // restart mid-run
      drive(1, 0, 0, 100);
      cyc1();
      idle_edges(9, 100);
      drive(1, 0, 0, 100);
      cyc1();
      idle_edges(4, 100);
      drive(0, 1, 0, 100);
      cyc1();
      chk_out("restart", 5, 1, 0, 0);
      drive(0, 0, 1, 100);
      cyc1();

      // shortest interval, then full-range overflow
      drive(1, 0, 0, 100);
      cyc1();
      drive(0, 1, 0, 100);
      cyc1();
      chk_out("stop_at_1", 1, 1, 0, 0);
      drive(0, 0, 1, 0);
      cyc1();
      drive(1, 0, 0, 0);
      cyc1();
      n = 0;
      do begin
         drive(0, 0, 0, 0);
         cyc1();
         n++;
      end while (!bus.valid && n < 1100);
      chk("lim0_edges", n, 1023);
      chk_out("lim0_ovf", 1023, 1, 1, 0);
      drive(0, 0, 1, 0);
      cyc1();

      // start ignored in HOLD; ack+start launches a new run
      drive(1, 0, 0, 50);
      cyc1();
      idle_edges(3, 50);
      drive(0, 1, 0, 50);
      cyc1();
      chk_out("hold_el4", 4, 1, 0, 0);
      drive(1, 0, 0, 50);
      cyc1();
      cyc1();
      chk_out("hold_start_ign", 4, 1, 0, 0);
      drive(1, 0, 1, 50);
      cyc1();
      chk_out("ack_start", 4, 0, 0, 1);
      idle_edges(5, 50);
      drive(0, 1, 0, 50);
      cyc1();
      chk_out("ack_start_run", 6, 1, 0, 0);

      // asynchronous reset at count 40
      do_reset();
      drive(1, 0, 0, 100);
      cyc1();
      idle_edges(39, 100);
      chk_out("pre_rst_busy", 0, 0, 0, 1);
      #2;
      rst = 1'b1;
      #1;
      chk_out("rst_async", 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      drive(0, 1, 0, 100);
      cyc1();
      drive(0, 0, 0, 100);
      cyc1();
      chk_out("rst_stop_ign", 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      drive(1, 0, 0, 100);
      cyc1();
      chk_out("first_start", 0, 0, 0, 1);

      // randomized run against the timestamp model
      do_reset();
      m_mode = 0;
      m_t0   = 0;
      m_cyc  = 0;
      m_el   = 0;
      m_ovf  = 1'b0;
      lim    = 1 + int'($urandom_range(0, 29));
      for (int i = 0; i < 4000; i++) begin
         s = ($urandom % 100) < 8;
         p = ($urandom % 100) < 6;
         a = ($urandom % 100) < 25;
         if (m_mode != 1 && ($urandom % 100) < 10)
            lim = (($urandom % 20) == 0) ? 0
                  : 1 + int'($urandom_range(0, 39));
         drive(s, p, a, lim);
         @(posedge clk);
         model_edge(s, p, a, lim);
         @(negedge clk);
         chk_out($sformatf("rand%0d", i), m_el, m_mode == 2,
                 m_ovf, m_mode == 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
